// File: rtl/button_debounce_repeat.sv
// Four-channel button conditioner: 2-flop synchronizer, counter debounce and
// frame-locked auto-repeat. A press pulses once, then repeats after a delay.
module button_debounce_repeat #(
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_FRAMES = 30,
  parameter int REPEAT_RATE_FRAMES  = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_buttons,
  input  logic       i_vsync,
  output logic [3:0] o_buttons,
  output logic [3:0] o_press,
  output logic       o_frame_tick
);

  localparam int DW    = $clog2(DEBOUNCE_CYCLES);
  localparam int FW_D  = $clog2(REPEAT_DELAY_FRAMES);
  localparam int FW_R  = $clog2(REPEAT_RATE_FRAMES);
  localparam int FW_DR = (FW_D > FW_R) ? FW_D : FW_R;
  localparam int FW    = (FW_DR > 1) ? FW_DR : 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE     = DW'(1);
  localparam bit            DELAY_EN   = (REPEAT_DELAY_FRAMES > 0);
  localparam logic [FW-1:0] DELAY_LAST = FW'((REPEAT_DELAY_FRAMES > 0) ? REPEAT_DELAY_FRAMES - 1 : 0);
  localparam logic [FW-1:0] RATE_LAST  = FW'((REPEAT_RATE_FRAMES > 0) ? REPEAT_RATE_FRAMES - 1 : 0);
  localparam logic [FW-1:0] FR_ONE     = FW'(1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic vsync_d;
  logic tick;

  // The FSMs act on the same-cycle edge so repeat pulses line up with o_frame_tick.
  assign tick = i_vsync & ~vsync_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vsync_d      <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      vsync_d      <= i_vsync;
      o_frame_tick <= tick;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic          sync1;
      logic          sync2;
      logic          stable;
      logic [DW-1:0] db_cnt;
      state_t        state;
      logic [FW-1:0] fr_cnt;
      logic          level;
      logic          press;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          sync1  <= 1'b0;
          sync2  <= 1'b0;
          stable <= 1'b0;
          db_cnt <= '0;
        end else begin
          sync1 <= i_buttons[gi];
          sync2 <= sync1;
          if (sync2 == stable) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            stable <= ~stable;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          state  <= IDLE;
          fr_cnt <= '0;
          level  <= 1'b0;
          press  <= 1'b0;
        end else begin
          level <= stable;
          press <= 1'b0;
          case (state)
            IDLE: begin
              if (stable) begin
                press  <= 1'b1;
                state  <= DELAY;
                fr_cnt <= '0;
              end
            end
            DELAY: begin
              if (!stable) begin
                state  <= IDLE;
                fr_cnt <= '0;
              end else if (tick) begin
                if (DELAY_EN && fr_cnt == DELAY_LAST) begin
                  // Inverting suppresses a pulse right after the initial press.
                  press  <= ~press;
                  state  <= REPEAT;
                  fr_cnt <= '0;
                end else begin
                  fr_cnt <= fr_cnt + FR_ONE;
                end
              end
            end
            REPEAT: begin
              if (!stable) begin
                state  <= IDLE;
                fr_cnt <= '0;
              end else if (tick) begin
                if (fr_cnt == RATE_LAST) begin
                  press  <= ~press;
                  fr_cnt <= '0;
                end else begin
                  fr_cnt <= fr_cnt + FR_ONE;
                end
              end
            end
            default: begin
              state  <= IDLE;
              fr_cnt <= '0;
            end
          endcase
        end
      end

      assign o_buttons[gi] = level;
      assign o_press[gi]   = press;
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat (debounce 4, delay 3 frames, rate 2 frames);
// a scoreboard holds expected press and frame-tick events by cycle.
module tb_button_debounce_repeat;

  logic       clk;
  logic       reset;
  logic [3:0] buttons;
  logic       vsync;
  logic [3:0] o_buttons;
  logic [3:0] o_press;
  logic       o_frame_tick;

  int cyc;
  int total;
  int passed;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } ev_t;

  ev_t press_q[$];
  int  tick_q[$];
  ev_t mon_ev;
  int  mon_tick;

  button_debounce_repeat #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_FRAMES(3),
    .REPEAT_RATE_FRAMES(2)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_buttons(buttons),
    .i_vsync(vsync),
    .o_buttons(o_buttons),
    .o_press(o_press),
    .o_frame_tick(o_frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic ev_t mk(input int c, input logic [3:0] m);
    ev_t e;
    e.cyc  = c;
    e.mask = m;
    return e;
  endfunction

  // Scoreboard: every press and frame tick the DUT emits must match the queue head.
  always @(negedge clk) begin
    if (o_press !== 4'h0) begin
      total++;
      if (press_q.size() == 0) begin
        $display("FAIL press_unexpected cyc=%0d got=%h want=none", cyc, o_press);
      end else begin
        mon_ev = press_q.pop_front();
        if (mon_ev.cyc !== cyc || mon_ev.mask !== o_press)
          $display("FAIL press_event cyc=%0d got=%h want cyc=%0d mask=%h", cyc, o_press, mon_ev.cyc, mon_ev.mask);
        else
          passed++;
      end
    end else if (press_q.size() > 0 && press_q[0].cyc < cyc) begin
      total++;
      mon_ev = press_q.pop_front();
      $display("FAIL press_missing cyc=%0d got=0 want cyc=%0d mask=%h", cyc, mon_ev.cyc, mon_ev.mask);
    end

    if (o_frame_tick !== 1'b0) begin
      total++;
      if (tick_q.size() == 0) begin
        $display("FAIL tick_unexpected cyc=%0d got=%b want=none", cyc, o_frame_tick);
      end else begin
        mon_tick = tick_q.pop_front();
        if (mon_tick !== cyc)
          $display("FAIL tick_event got cyc=%0d want cyc=%0d", cyc, mon_tick);
        else
          passed++;
      end
    end else if (tick_q.size() > 0 && tick_q[0] < cyc) begin
      total++;
      mon_tick = tick_q.pop_front();
      $display("FAIL tick_missing cyc=%0d got=0 want cyc=%0d", cyc, mon_tick);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int c;
    reset   = 1'b1;
    buttons = 4'hF;
    vsync   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({o_buttons, o_press, o_frame_tick} !== 9'h0)
        $display("FAIL reset_outputs cyc=%0d got=%h want=000", cyc, {o_buttons, o_press, o_frame_tick});
      else
        passed++;
      vsync = i[1];
    end
    vsync = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    press_q.push_back(mk(c + 7, 4'hF));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (o_buttons !== ((cyc >= c + 7) ? 4'hF : 4'h0))
        $display("FAIL held_through_reset cyc=%0d got=%h want=%h", cyc, o_buttons, (cyc >= c + 7) ? 4'hF : 4'h0);
      else
        passed++;
    end
    buttons = 4'h0;
    wait_n(10);
    total++;
    if (o_buttons !== 4'h0)
      $display("FAIL reset_release_all got=%h want=0", o_buttons);
    else
      passed++;
  endtask

  task automatic test_glitch;
    @(negedge clk);
    buttons[0] = 1'b1;
    wait_n(3);
    buttons[0] = 1'b0;
    wait_n(1);
    buttons[0] = 1'b1;
    wait_n(3);
    buttons[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (o_buttons !== 4'h0)
        $display("FAIL glitch_level cyc=%0d got=%h want=0", cyc, o_buttons);
      else
        passed++;
    end
  endtask

  task automatic test_press_latency;
    int c;
    @(negedge clk);
    buttons[2] = 1'b1;
    c = cyc;
    press_q.push_back(mk(c + 7, 4'b0100));
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      total++;
      if (o_buttons[2] !== (cyc >= c + 7))
        $display("FAIL press_latency cyc=%0d got=%b want=%b", cyc, o_buttons[2], (cyc >= c + 7));
      else
        passed++;
    end
    buttons[2] = 1'b0;
    wait_n(10);
    total++;
    if (o_buttons !== 4'h0)
      $display("FAIL press_release got=%h want=0", o_buttons);
    else
      passed++;
  endtask

  task automatic test_repeat;
    @(negedge clk);
    buttons[1] = 1'b1;
    press_q.push_back(mk(cyc + 7, 4'b0010));
    wait_n(10);
    for (int f = 1; f <= 7; f++) begin
      for (int p = 0; p < 20; p++) begin
        @(negedge clk);
        vsync = (p < 5);
        if (p == 0) begin
          tick_q.push_back(cyc + 1);
          if (f == 3 || f == 5 || f == 7)
            press_q.push_back(mk(cyc + 1, 4'b0010));
        end
      end
    end
    total++;
    if (o_buttons !== 4'b0010)
      $display("FAIL repeat_level got=%h want=2", o_buttons);
    else
      passed++;
  endtask

  task automatic test_release_on_tick;
    int d;
    d = 0;
    for (int f = 8; f <= 9; f++) begin
      for (int p = 0; p < 20; p++) begin
        @(negedge clk);
        if (f == 9 && p == 1) begin
          total++;
          if (o_buttons[1] !== 1'b0 || o_frame_tick !== 1'b1 || cyc !== d + 7)
            $display("FAIL release_on_tick cyc=%0d got btn=%b tick=%b want btn=0 tick=1 cyc=%0d", cyc, o_buttons[1], o_frame_tick, d + 7);
          else
            passed++;
        end
        vsync = (p < 5);
        if (p == 0) tick_q.push_back(cyc + 1);
        if (f == 8 && p == 14) begin
          buttons[1] = 1'b0;
          d = cyc;
        end
      end
    end
    @(negedge clk);
    buttons[1] = 1'b1;
    press_q.push_back(mk(cyc + 7, 4'b0010));
    wait_n(12);
    total++;
    if (o_buttons[1] !== 1'b1)
      $display("FAIL repress_level got=%b want=1", o_buttons[1]);
    else
      passed++;
    buttons[1] = 1'b0;
    wait_n(10);
  endtask

  task automatic test_reset_mid_repeat;
    int c;
    @(negedge clk);
    buttons[3] = 1'b1;
    press_q.push_back(mk(cyc + 7, 4'b1000));
    wait_n(10);
    for (int f = 1; f <= 4; f++) begin
      for (int p = 0; p < ((f == 4) ? 10 : 20); p++) begin
        @(negedge clk);
        vsync = (p < 5);
        if (p == 0) begin
          tick_q.push_back(cyc + 1);
          if (f == 3) press_q.push_back(mk(cyc + 1, 4'b1000));
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({o_buttons, o_press, o_frame_tick} !== 9'h0)
      $display("FAIL async_reset got=%h want=000", {o_buttons, o_press, o_frame_tick});
    else
      passed++;
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    press_q.push_back(mk(c + 7, 4'b1000));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (o_buttons !== ((cyc >= c + 7) ? 4'b1000 : 4'b0000))
        $display("FAIL reset_repress cyc=%0d got=%h want=%h", cyc, o_buttons, (cyc >= c + 7) ? 4'b1000 : 4'b0000);
      else
        passed++;
    end
    // One tick after reset: back in DELAY with a fresh counter, so no pulse.
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      vsync = (p < 5);
      if (p == 0) tick_q.push_back(cyc + 1);
    end
    buttons[3] = 1'b0;
    wait_n(10);
  endtask

  initial begin
    cyc     = 0;
    total   = 0;
    passed  = 0;
    reset   = 1'b1;
    buttons = 4'h0;
    vsync   = 1'b0;
    test_reset();
    test_glitch();
    test_press_latency();
    test_repeat();
    test_release_on_tick();
    test_reset_mid_repeat();
    wait_n(3);
    total++;
    if (press_q.size() !== 0)
      $display("FAIL press_queue_left got=%0d want=0", press_q.size());
    else
      passed++;
    total++;
    if (tick_q.size() !== 0)
      $display("FAIL tick_queue_left got=%0d want=0", tick_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
